pixel_ray_issuer: RTL and testbench

//  Raster-scans one frame of pixel coordinates into eye_to_pixel (x_in/y_in) and re-pairs each

---
 rtl/pixel_ray_issuer_if.sv | 35 +++
 rtl/pixel_ray_issuer.sv | 167 ++++++++++++++++
 tb/tb_pixel_ray_issuer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_ray_issuer_if.sv
// Bus bundle for pixel_ray_issuer.
//  Issue side : x_out / y_out / issue_valid_out   -> eye_to_pixel
//  Return side: dir_x_in / dir_y_in / dir_z_in / dir_valid_in <- eye_to_pixel
//  Ray side   : ray_* / ray_valid_out / ray_ready_in (valid/ready to consumer)
// master = the issuer, slave = its environment.
interface pixel_ray_issuer_if;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        issue_valid_out;
  logic [31:0] dir_x_in;
  logic [31:0] dir_y_in;
  logic [31:0] dir_z_in;
  logic        dir_valid_in;
  logic [10:0] ray_x_out;
  logic [9:0]  ray_y_out;
  logic [31:0] ray_dir_x_out;
  logic [31:0] ray_dir_y_out;
  logic [31:0] ray_dir_z_out;
  logic        ray_valid_out;
  logic        ray_ready_in;

  modport master (
    output x_out, y_out, issue_valid_out,
    input  dir_x_in, dir_y_in, dir_z_in, dir_valid_in,
    output ray_x_out, ray_y_out, ray_dir_x_out, ray_dir_y_out, ray_dir_z_out, ray_valid_out,
    input  ray_ready_in
  );

  modport slave (
    input  x_out, y_out, issue_valid_out,
    output dir_x_in, dir_y_in, dir_z_in, dir_valid_in,
    input  ray_x_out, ray_y_out, ray_dir_x_out, ray_dir_y_out, ray_dir_z_out, ray_valid_out,
    output ray_ready_in
  );
endinterface

// File: rtl/pixel_ray_issuer.sv
// pixel_ray_issuer
//  Raster-scans one frame of pixel coordinates into a fixed-latency direction
//  pipeline, re-pairs each returned direction with the coordinate that produced
//  it (tag FIFO) and presents (x, y, dir) rays on a valid/ready handshake.
//  Issue is credit-limited so every pixel in flight has a result slot waiting.
// Ports
//  clk_in, rst_in    clock, synchronous active-high reset
//  start_in          begin a frame (only looked at in IDLE)
//  bus (master)      issue bus, direction return bus, ray output handshake
//  busy_out          frame in progress
//  frame_done_out    one-cycle pulse once the last ray of the frame is accepted
//  sync_err_out      sticky: a direction returned with no pixel outstanding
module pixel_ray_issuer #(
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 180,
  parameter int DEPTH    = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  pixel_ray_issuer_if.master bus,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               sync_err_out
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int TAG_W = 21;
  localparam int RES_W = TAG_W + 96;
  localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
  localparam logic [10:0]   X_LAST    = 11'(H_PIXELS - 1);
  localparam logic [9:0]    Y_LAST    = 10'(V_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [10:0]       x_p0;
  logic [9:0]        y_p0;
  logic              vld_p0;
  logic              done_d;
  logic [CW-1:0]     credits;

  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]     tag_wr, tag_rd;
  logic [CW-1:0]     tag_cnt;
  logic [RES_W-1:0]  res_mem [DEPTH];
  logic [AW-1:0]     res_wr, res_rd;
  logic [CW-1:0]     res_cnt;

  logic              tag_pop, sync_hit, ray_valid, ray_fire;
  logic [RES_W-1:0]  head;

  // Credits saturate at both ends; a simultaneous take and give cancel out.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c,
                                                input logic take, input logic give);
    logic [CW-1:0] r;
    r = c;
    if (take && !give && c != '0)
      r = c - CW'(1);
    else if (give && !take && c != CRED_FULL)
      r = c + CW'(1);
    return r;
  endfunction

  assign tag_pop   = bus.dir_valid_in && (tag_cnt != '0);
  assign sync_hit  = bus.dir_valid_in && (tag_cnt == '0);
  assign ray_valid = (res_cnt != '0);
  assign ray_fire  = ray_valid && bus.ray_ready_in;
  assign head      = res_mem[res_rd];
  assign busy_out  = (state_q != IDLE);

  // Stage p0: frame sequencing and credit-gated issue decision
  always_comb begin
    state_d = state_q;
    vld_p0  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (start_in) state_d = SCAN;
      SCAN: begin
        if (credits != '0) begin
          vld_p0 = 1'b1;
          if (x_p0 == X_LAST && y_p0 == Y_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (credits == CRED_FULL) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q             <= IDLE;
      x_p0                <= '0;
      y_p0                <= '0;
      credits             <= CRED_FULL;
      bus.x_out           <= '0;
      bus.y_out           <= '0;
      bus.issue_valid_out <= 1'b0;
      frame_done_out      <= 1'b0;
      sync_err_out        <= 1'b0;
      tag_wr              <= '0;
      tag_rd              <= '0;
      tag_cnt             <= '0;
      res_wr              <= '0;
      res_rd              <= '0;
      res_cnt             <= '0;
    end else begin
      state_q             <= state_d;
      frame_done_out      <= done_d;
      bus.issue_valid_out <= vld_p0;
      credits             <= credit_next(credits, vld_p0, ray_fire);

      if (state_q == IDLE && start_in) begin
        x_p0         <= '0;
        y_p0         <= '0;
        sync_err_out <= 1'b0;
      end else if (vld_p0) begin
        bus.x_out <= x_p0;
        bus.y_out <= y_p0;
        if (x_p0 == X_LAST) begin
          x_p0 <= '0;
          y_p0 <= y_p0 + 10'd1;
        end else begin
          x_p0 <= x_p0 + 11'd1;
        end
      end

      // A direction with nothing outstanding is dropped and flagged.
      if (sync_hit) sync_err_out <= 1'b1;

      if (vld_p0)  tag_wr <= tag_wr + AW'(1);
      if (tag_pop) tag_rd <= tag_rd + AW'(1);
      case ({vld_p0, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase

      if (tag_pop)  res_wr <= res_wr + AW'(1);
      if (ray_fire) res_rd <= res_rd + AW'(1);
      case ({tag_pop, ray_fire})
        2'b10:   res_cnt <= res_cnt + CW'(1);
        2'b01:   res_cnt <= res_cnt - CW'(1);
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  // Stage p1: tag capture on issue, tag+direction pairing on return
  always_ff @(posedge clk_in) begin
    if (vld_p0)  tag_mem[tag_wr] <= {x_p0, y_p0};
    if (tag_pop) res_mem[res_wr] <= {tag_mem[tag_rd], bus.dir_x_in, bus.dir_y_in, bus.dir_z_in};
  end

  // Stage p2: show-ahead head of the result FIFO, zeroed while empty
  assign bus.ray_valid_out = ray_valid;
  assign bus.ray_x_out     = ray_valid ? head[116:106] : '0;
  assign bus.ray_y_out     = ray_valid ? head[105:96]  : '0;
  assign bus.ray_dir_x_out = ray_valid ? head[95:64]   : '0;
  assign bus.ray_dir_y_out = ray_valid ? head[63:32]   : '0;
  assign bus.ray_dir_z_out = ray_valid ? head[31:0]    : '0;
endmodule

// File: tb/tb_pixel_ray_issuer.sv
module tb_pixel_ray_issuer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: H4 V2 D16, instance 1: H8 V4 D4, instance 2: H4 V4 D2
  function automatic int hp(input int g); return (g == 1) ? 8 : 4; endfunction
  function automatic int vp(input int g); return (g == 0) ? 2 : 4; endfunction
  function automatic int dp(input int g); return (g == 0) ? 16 : ((g == 1) ? 4 : 2); endfunction

  int checks = 0;
  int failures = 0;

  logic [2:0]  rst, start, ready, inj, clr;
  logic [2:0]  iv, rv, busy, done, serr, dv;
  logic [31:0] inj_d;
  logic [10:0] ix [3];
  logic [9:0]  iy [3];
  logic [10:0] rxo [3];
  logic [9:0]  ryo [3];
  logic [31:0] rdx [3], rdy [3], rdz [3];
  logic [31:0] dvx [3], dvy [3], dvz [3];

  // eye_to_pixel model: 7-cycle delay line
  logic        pv [3][7];
  logic [10:0] px [3][7];
  logic [9:0]  py [3][7];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    pixel_ray_issuer_if bif();
    pixel_ray_issuer #(.H_PIXELS(hp(g)), .V_PIXELS(vp(g)), .DEPTH(dp(g))) dut (
      .clk_in(clk), .rst_in(rst[g]), .start_in(start[g]), .bus(bif),
      .busy_out(busy[g]), .frame_done_out(done[g]), .sync_err_out(serr[g]));
    assign iv[g]  = bif.issue_valid_out;
    assign ix[g]  = bif.x_out;
    assign iy[g]  = bif.y_out;
    assign rv[g]  = bif.ray_valid_out;
    assign rxo[g] = bif.ray_x_out;
    assign ryo[g] = bif.ray_y_out;
    assign rdx[g] = bif.ray_dir_x_out;
    assign rdy[g] = bif.ray_dir_y_out;
    assign rdz[g] = bif.ray_dir_z_out;
    assign bif.ray_ready_in = ready[g];
    assign bif.dir_valid_in = dv[g];
    assign bif.dir_x_in     = dvx[g];
    assign bif.dir_y_in     = dvy[g];
    assign bif.dir_z_in     = dvz[g];
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst[g]) begin
        for (int s = 0; s < 7; s++) pv[g][s] <= 1'b0;
      end else begin
        pv[g][0] <= iv[g];
        px[g][0] <= ix[g];
        py[g][0] <= iy[g];
        for (int s = 1; s < 7; s++) begin
          pv[g][s] <= pv[g][s-1];
          px[g][s] <= px[g][s-1];
          py[g][s] <= py[g][s-1];
        end
      end
    end
  end

  always_comb begin
    dv = '0;
    for (int g = 0; g < 3; g++) begin
      dv[g]  = pv[g][6] | inj[g];
      dvx[g] = inj[g] ? inj_d : {21'b0, px[g][6]};
      dvy[g] = inj[g] ? inj_d : {22'b0, py[g][6]};
      dvz[g] = inj[g] ? inj_d : 32'h3F80_0000;
    end
  end

  // Monitor: ray log, issue/handshake counts, outstanding window, hold stability
  int iss_n [3], hs_n [3], done_n [3], done_hs [3], max_out [3], min_out [3], stab_err [3];
  logic [116:0] rlog [3][64];
  logic [116:0] prev_ray [3];
  logic         prev_hold [3];
  logic [116:0] cur;
  int           outst;

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (clr[g]) begin
          iss_n[g] = 0; hs_n[g] = 0; done_n[g] = 0; done_hs[g] = -1;
          max_out[g] = 0; min_out[g] = 0; stab_err[g] = 0; prev_hold[g] = 1'b0;
          for (int i = 0; i < 64; i++) rlog[g][i] = '1;
        end
        cur = {rxo[g], ryo[g], rdx[g], rdy[g], rdz[g]};
        if (prev_hold[g] && (rv[g] !== 1'b1 || cur !== prev_ray[g])) stab_err[g]++;
        prev_hold[g] = (rv[g] === 1'b1) && (ready[g] === 1'b0);
        prev_ray[g]  = cur;
        if (iv[g] === 1'b1) iss_n[g]++;
        outst = iss_n[g] - hs_n[g];
        if (outst > max_out[g]) max_out[g] = outst;
        if (outst < min_out[g]) min_out[g] = outst;
        if (done[g] === 1'b1) begin done_n[g]++; done_hs[g] = hs_n[g]; end
        if (rv[g] === 1'b1 && ready[g] === 1'b1) begin
          if (hs_n[g] < 64) rlog[g][hs_n[g]] = cur;
          hs_n[g]++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [116:0] exp_ray(input int g, input int i);
    int x, y;
    x = i % hp(g);
    y = i / hp(g);
    return {11'(x), 10'(y), 32'(x), 32'(y), 32'h3F80_0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear(input int g);
    clr[g] = 1'b1;
    tick();
    clr[g] = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  // mode 0: ready held, 1: ready toggles every cycle, 2: random ready
  task automatic wait_done(input int g, input int budget, input int mode, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (mode == 1) ready[g] = ~ready[g];
      else if (mode == 2) ready[g] = 1'(($urandom % 2));
      tick();
      if (done[g] === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = '1; start = '0; ready = '0; inj = '0; clr = '1; inj_d = '0;
    repeat (3) tick();
    rst = '0; clr = '0;
    tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({iv[g], rv[g], busy[g], done[g], serr[g]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_flags[%0d]: got %b want 00000", g, {iv[g], rv[g], busy[g], done[g], serr[g]});
      end
      checks++;
      if ({ix[g], iy[g]} !== 21'b0) begin
        failures++;
        $display("FAIL reset_xy[%0d]: got %h want 0", g, {ix[g], iy[g]});
      end
      checks++;
      if ({rxo[g], ryo[g], rdx[g], rdy[g], rdz[g]} !== 117'b0) begin
        failures++;
        $display("FAIL reset_ray[%0d]: got %h want 0", g, {rxo[g], ryo[g], rdx[g], rdy[g], rdz[g]});
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear(0);
    ready[0] = 1'b1;
    repeat ($urandom_range(0, 3)) tick();
    pulse_start(0);
    checks++;
    if (busy[0] !== 1'b1 || iv[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_start_edge: got busy=%b issue=%b want busy=1 issue=0", busy[0], iv[0]);
    end
    tick();
    checks++;
    if (iv[0] !== 1'b1 || ix[0] !== 11'd0 || iy[0] !== 10'd0) begin
      failures++;
      $display("FAIL basic_first_issue: got v=%b (%0d,%0d) want v=1 (0,0)", iv[0], ix[0], iy[0]);
    end
    tick();
    checks++;
    if (iv[0] !== 1'b1 || ix[0] !== 11'd1 || iy[0] !== 10'd0) begin
      failures++;
      $display("FAIL basic_second_issue: got v=%b (%0d,%0d) want v=1 (1,0)", iv[0], ix[0], iy[0]);
    end
    wait_done(0, 200, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got no frame_done want frame_done"); end
    checks++;
    if (hs_n[0] != 8) begin failures++; $display("FAIL basic_count: got %0d want 8", hs_n[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rlog[0][i] !== exp_ray(0, i)) begin
        failures++;
        $display("FAIL basic_ray[%0d]: got %h want %h", i, rlog[0][i], exp_ray(0, i));
      end
    end
    checks++;
    if (done_n[0] != 1 || done_hs[0] != 8) begin
      failures++;
      $display("FAIL basic_done: got pulses=%0d after=%0d want pulses=1 after=8", done_n[0], done_hs[0]);
    end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy[0]); end
  endtask

  task automatic test_stall();
    bit ok;
    clear(1);
    ready[1] = 1'b0;
    pulse_start(1);
    repeat (40) tick();
    checks++;
    if (iss_n[1] != 4) begin failures++; $display("FAIL stall_issues: got %0d want 4", iss_n[1]); end
    checks++;
    if ({rv[1], rxo[1], ryo[1], rdz[1]} !== {1'b1, 11'd0, 10'd0, 32'h3F80_0000}) begin
      failures++;
      $display("FAIL stall_head: got v=%b (%0d,%0d) z=%h want v=1 (0,0) z=3f800000", rv[1], rxo[1], ryo[1], rdz[1]);
    end
    checks++;
    if (busy[1] !== 1'b1) begin failures++; $display("FAIL stall_busy: got %b want 1", busy[1]); end
    ready[1] = 1'b1;
    wait_done(1, 600, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_timeout: got no frame_done want frame_done"); end
    checks++;
    if (hs_n[1] != 32) begin failures++; $display("FAIL stall_count: got %0d want 32", hs_n[1]); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rlog[1][i] !== exp_ray(1, i)) begin
        failures++;
        $display("FAIL stall_ray[%0d]: got %h want %h", i, rlog[1][i], exp_ray(1, i));
      end
    end
    checks++;
    if (stab_err[1] != 0 || max_out[1] > 4) begin
      failures++;
      $display("FAIL stall_hold: got unstable=%0d max_outstanding=%0d want 0 and <=4", stab_err[1], max_out[1]);
    end
    checks++;
    if (done_n[1] != 1) begin failures++; $display("FAIL stall_done: got %0d want 1", done_n[1]); end
  endtask

  task automatic test_restart();
    bit ok;
    bit seen;
    clear(0);
    ready[0] = 1'b1;
    pulse_start(0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      ready[0] = 1'(($urandom % 2));
      tick();
      if (iss_n[0] >= 3) seen = 1'b1;
    end
    start[0] = 1'b1;
    repeat (2) tick();
    start[0] = 1'b0;
    wait_done(0, 400, 2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL restart_timeout: got no frame_done want frame_done"); end
    repeat (10) tick();
    checks++;
    if (iss_n[0] != 8 || hs_n[0] != 8) begin
      failures++;
      $display("FAIL restart_count: got issues=%0d rays=%0d want 8/8", iss_n[0], hs_n[0]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rlog[0][i] !== exp_ray(0, i)) begin
        failures++;
        $display("FAIL restart_ray[%0d]: got %h want %h", i, rlog[0][i], exp_ray(0, i));
      end
    end
    checks++;
    if (done_n[0] != 1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL restart_done: got pulses=%0d busy=%b want 1/0", done_n[0], busy[0]);
    end
  endtask

  task automatic test_sync_err();
    bit ok;
    clear(0);
    ready[0] = 1'b1;
    inj_d = $urandom;
    inj[0] = 1'b1;
    tick();
    inj[0] = 1'b0;
    checks++;
    if (serr[0] !== 1'b1 || rv[0] !== 1'b0) begin
      failures++;
      $display("FAIL sync_set: got err=%b ray_valid=%b want 1/0", serr[0], rv[0]);
    end
    repeat (5) tick();
    checks++;
    if (serr[0] !== 1'b1 || rv[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL sync_sticky: got err=%b ray_valid=%b busy=%b want 1/0/0", serr[0], rv[0], busy[0]);
    end
    pulse_start(0);
    checks++;
    if (serr[0] !== 1'b0) begin failures++; $display("FAIL sync_clear: got %b want 0", serr[0]); end
    wait_done(0, 200, 0, ok);
    checks++;
    if (!ok || hs_n[0] != 8) begin
      failures++;
      $display("FAIL sync_frame: got done=%0d rays=%0d want 1/8", ok, hs_n[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    clear(2);
    ready[2] = 1'b1;
    pulse_start(2);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick();
      if (iv[2] === 1'b1 && ix[2] === 11'd2 && iy[2] === 10'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rstmid_reach: got no issue of (2,1) want issue"); end
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    checks++;
    if ({iv[2], rv[2], busy[2], done[2], serr[2], ix[2], iy[2], rxo[2], ryo[2], rdx[2]} !== 0) begin
      failures++;
      $display("FAIL rstmid_outputs: got %h want 0",
               {iv[2], rv[2], busy[2], done[2], serr[2], ix[2], iy[2], rxo[2], ryo[2], rdx[2]});
    end
    clear(2);
    pulse_start(2);
    wait_done(2, 600, 0, ok);
    checks++;
    if (!ok || hs_n[2] != 16) begin
      failures++;
      $display("FAIL rstmid_frame: got done=%0d rays=%0d want 1/16", ok, hs_n[2]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rlog[2][i] !== exp_ray(2, i)) begin
        failures++;
        $display("FAIL rstmid_ray[%0d]: got %h want %h", i, rlog[2][i], exp_ray(2, i));
      end
    end
  endtask

  task automatic test_toggle(input int g, input int mode);
    bit ok;
    int n;
    n = hp(g) * vp(g);
    clear(g);
    ready[g] = 1'(($urandom % 2));
    pulse_start(g);
    wait_done(g, 2000, mode, ok);
    ready[g] = 1'b1;
    checks++;
    if (!ok || hs_n[g] != n || done_n[g] != 1) begin
      failures++;
      $display("FAIL toggle%0d_frame: got done=%0d rays=%0d pulses=%0d want 1/%0d/1", g, ok, hs_n[g], done_n[g], n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rlog[g][i] !== exp_ray(g, i)) begin
        failures++;
        $display("FAIL toggle%0d_ray[%0d]: got %h want %h", g, i, rlog[g][i], exp_ray(g, i));
      end
    end
    checks++;
    if (max_out[g] > dp(g) || min_out[g] < 0 || stab_err[g] != 0) begin
      failures++;
      $display("FAIL toggle%0d_window: got max=%0d min=%0d unstable=%0d want <=%0d >=0 0",
               g, max_out[g], min_out[g], stab_err[g], dp(g));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_sync_err();
    test_reset_mid();
    test_toggle(2, 1);
    test_toggle(1, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
